// File: rtl/test_seq_pkg.sv
// Shared types and constants for the vector test sequencer.
// No logic; no latency; no backpressure.
// Holds the FSM state enum, bus widths, parameter defaults and the signature step.
package test_seq_pkg;

    localparam int SIG_W           = 32;
    localparam int ADDR_W          = 3;
    localparam int CNT_W           = 4;
    localparam int TMO_W           = 8;
    localparam int NUM_VECTORS_DEF = 7;
    localparam int WAIT_MAX_DEF    = 255;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_RESP,
        DONE,
        ERR
    } state_t;

    // Rotate-left-by-one then fold in the new response word.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] resp);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ resp;
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// Response watchdog: counts idle wait cycles and flags when the limit is reached.
// Latency: expired is combinational, asserted in the cycle whose count step hits limit.
// Backpressure: none; clr wins over en.
module seq_timeout
    import test_seq_pkg::*;
#(
    parameter int W = TMO_W
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // Fires when this cycle's increment would make the count equal limit.
    assign expired = en && (cnt == (limit - W'(1)));

endmodule

// File: rtl/test_mem.sv
// Vector ROM feeding the sequencer; lives beside test_seq, not inside it.
// Latency: combinational read.
// Backpressure: none, the word is always available.
module test_mem
    import test_seq_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [SIG_W-1:0]  data
);

    always_comb begin
        data = '0;
        case (addr)
            3'd0:    data = 32'hff00_f00f;
            3'd1:    data = 32'h7001_1585;
            3'd2:    data = 32'h0402_0202;
            3'd3:    data = 32'hf003_fff0;
            3'd4:    data = 32'h7f04_700f;
            3'd5:    data = 32'hff05_f00f;
            3'd6:    data = 32'h0f06_00f0;
            default: data = 32'hdead_beef;
        endcase
    end

endmodule

// File: rtl/test_seq.sv
// Vector test sequencer: fetch word from test_mem, offer it, collect a response, fold signature.
// Latency: vec_valid rises two cycles after start; one FETCH/SEND/WAIT_RESP loop per vector.
// Backpressure: vector held in SEND until vec_ready_i; response wait bounded by WAIT_MAX.
module test_seq
    import test_seq_pkg::*;
#(
    parameter int NUM_VECTORS = NUM_VECTORS_DEF,
    parameter int WAIT_MAX    = WAIT_MAX_DEF
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [SIG_W-1:0]  mem_data_i,
    output logic              vec_valid,
    output logic [SIG_W-1:0]  vec_data,
    input  logic              vec_ready_i,
    input  logic              resp_valid_i,
    input  logic [SIG_W-1:0]  resp_data_i,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_count
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_VECTORS);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(WAIT_MAX);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [SIG_W-1:0]  data_nxt;
    logic [SIG_W-1:0]  sig_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              terr_nxt;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expired;

    seq_timeout #(.W(TMO_W)) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );

    assign cnt_inc = vec_count + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_addr    <= '0;
            vec_data    <= '0;
            signature   <= '0;
            vec_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_addr    <= addr_nxt;
            vec_data    <= data_nxt;
            signature   <= sig_nxt;
            vec_count   <= cnt_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        data_nxt  = vec_data;
        sig_nxt   = signature;
        cnt_nxt   = vec_count;
        terr_nxt  = timeout_err;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = FETCH;
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                    sig_nxt   = '0;
                    terr_nxt  = 1'b0;
                end
            end
            FETCH: begin
                data_nxt  = mem_data_i;
                state_nxt = SEND;
            end
            SEND: begin
                if (vec_ready_i) begin
                    state_nxt = WAIT_RESP;
                    tmo_clr   = 1'b1;
                end
            end
            WAIT_RESP: begin
                // A response in the expiry cycle keeps en low, so it always beats the timeout.
                if (resp_valid_i) begin
                    sig_nxt = sig_step(signature, resp_data_i);
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == LAST_CNT) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = mem_addr + ADDR_W'(1);
                        state_nxt = FETCH;
                    end
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        terr_nxt  = 1'b1;
                        state_nxt = ERR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign vec_valid = (state == SEND);
    assign busy      = (state == FETCH) || (state == SEND) || (state == WAIT_RESP);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_test_seq.sv
// Scoreboard bench for test_seq: a reference model queues expected vectors and run outcomes.
module tb_test_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_start, a_vec_ready, a_resp_valid;
    logic [31:0] a_resp_data, a_mem_data, a_vec_data, a_signature;
    logic [2:0]  a_mem_addr;
    logic        a_vec_valid, a_busy, a_done, a_terr;
    logic [3:0]  a_vec_count;

    logic        b_start, b_vec_ready, b_resp_valid;
    logic [31:0] b_resp_data, b_mem_data, b_vec_data, b_signature;
    logic [2:0]  b_mem_addr;
    logic        b_vec_valid, b_busy, b_done, b_terr;
    logic [3:0]  b_vec_count;

    test_seq #(.NUM_VECTORS(7), .WAIT_MAX(4)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .mem_addr(a_mem_addr),
        .mem_data_i(a_mem_data), .vec_valid(a_vec_valid), .vec_data(a_vec_data),
        .vec_ready_i(a_vec_ready), .resp_valid_i(a_resp_valid), .resp_data_i(a_resp_data),
        .busy(a_busy), .done(a_done), .timeout_err(a_terr), .signature(a_signature),
        .vec_count(a_vec_count)
    );
    test_mem u_mem_a (.addr(a_mem_addr), .data(a_mem_data));

    test_seq #(.NUM_VECTORS(2), .WAIT_MAX(255)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .mem_addr(b_mem_addr),
        .mem_data_i(b_mem_data), .vec_valid(b_vec_valid), .vec_data(b_vec_data),
        .vec_ready_i(b_vec_ready), .resp_valid_i(b_resp_valid), .resp_data_i(b_resp_data),
        .busy(b_busy), .done(b_done), .timeout_err(b_terr), .signature(b_signature),
        .vec_count(b_vec_count)
    );
    test_mem u_mem_b (.addr(b_mem_addr), .data(b_mem_data));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int b_done_n = 0;

    logic [31:0] mem_img [0:7] = '{32'hff00f00f, 32'h70011585, 32'h04020202, 32'hf003fff0,
                                   32'h7f04700f, 32'hff05f00f, 32'h0f0600f0, 32'hdeadbeef};

    typedef struct { int idx; logic [31:0] data; } vec_t;
    typedef struct { int kind; logic [31:0] sig; int cnt; int lat; } end_t; // kind: 0 done, 1 timeout, 2 reset
    vec_t exp_vec[$];
    end_t exp_end[$];

    logic [31:0] m_sig;
    int          m_cnt;
    int          a_timeout_at = -1;
    int          a_tie_at     = -1;
    bit          a_echo       = 1'b1;
    bit          a_noise      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (b_done) b_done_n <= b_done_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotx(input logic [31:0] s, input logic [31:0] d);
        return ((s << 1) | (s >> 31)) ^ d;
    endfunction

    function automatic void push_vec(input int i);
        vec_t v;
        v.idx  = i;
        v.data = mem_img[i];
        exp_vec.push_back(v);
    endfunction

    function automatic void push_end(input int kind, input logic [31:0] sig, input int cnt, input int lat);
        end_t e;
        e.kind = kind; e.sig = sig; e.cnt = cnt; e.lat = lat;
        exp_end.push_back(e);
    endfunction

    // Responder: answers each accepted vector, or withholds the answer to provoke a timeout.
    initial begin : responder
        logic [31:0] echo;
        int d;
        int idx;
        a_resp_valid = 1'b0;
        a_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && a_vec_valid && a_vec_ready) begin
                echo = a_vec_data;
                idx  = m_cnt;
                @(posedge clk); #1;
                a_resp_valid = 1'b0;
                if (idx == a_timeout_at) begin
                    push_end(1, m_sig, m_cnt, 4);
                    repeat (4) @(posedge clk);
                end else begin
                    d = (idx == a_tie_at) ? 3 : int'($urandom_range(0, 2));
                    repeat (d) begin @(posedge clk); #1; end
                    a_resp_valid = 1'b1;
                    a_resp_data  = a_echo ? echo : $urandom;
                    m_sig = rotx(m_sig, a_resp_data);
                    m_cnt++;
                    if (m_cnt == 7) push_end(0, m_sig, m_cnt, -1);
                    else            push_vec(m_cnt);
                    @(posedge clk); #1;
                    a_resp_valid = 1'b0;
                end
            end else begin
                a_resp_valid = a_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                a_resp_data  = $urandom;
            end
        end
    end

    initial begin : monitor
        bit   prev_busy;
        bit   chk_done_low;
        int   hs_cyc;
        end_t e;
        prev_busy = 1'b0; chk_done_low = 1'b0; hs_cyc = 0;
        forever begin
            @(negedge clk);
            if (chk_done_low) begin
                chk("done_one_cycle", a_done, 0);
                chk_done_low = 1'b0;
            end
            if (a_vec_valid) begin
                if (exp_vec.size() == 0) begin
                    total++; bad++;
                    $display("FAIL vec_unexpected: got %h expected no vector", a_vec_data);
                end else begin
                    chk("vec_data", a_vec_data, exp_vec[0].data);
                    chk("mem_addr", 32'(a_mem_addr), exp_vec[0].idx);
                    if (a_vec_ready) begin
                        void'(exp_vec.pop_front());
                        hs_cyc = cyc + 1;
                    end
                end
            end
            if (prev_busy && !a_busy) begin
                if (exp_end.size() == 0) begin
                    total++; bad++;
                    $display("FAIL end_unexpected: got run end expected none");
                end else begin
                    e = exp_end.pop_front();
                    chk("end_done", 32'(a_done), 32'(e.kind == 0));
                    chk("end_terr", 32'(a_terr), 32'(e.kind == 1));
                    chk("end_sig", a_signature, e.sig);
                    chk("end_cnt", 32'(a_vec_count), e.cnt);
                    if (e.lat >= 0) chk("end_lat", cyc - hs_cyc, e.lat);
                    if (e.kind == 2) begin
                        chk("rst_addr", 32'(a_mem_addr), 0);
                        chk("rst_valid", 32'(a_vec_valid), 0);
                        chk("rst_data", a_vec_data, 0);
                    end
                    if (e.kind == 0) chk_done_low = 1'b1;
                end
            end
            prev_busy = a_busy;
        end
    end

    task automatic start_a();
        @(posedge clk); #1;
        m_sig = '0;
        m_cnt = 0;
        push_vec(0);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        @(negedge clk);
        chk("start_busy", 32'(a_busy), 1);
        chk("start_valid_early", 32'(a_vec_valid), 0);
        chk("start_terr_clr", 32'(a_terr), 0);
        chk("start_cnt_clr", 32'(a_vec_count), 0);
        chk("start_sig_clr", a_signature, 0);
        @(negedge clk);
        chk("start_valid_lat2", 32'(a_vec_valid), 1);
    endtask

    task automatic run_a(input bit rnd_ready, input bit spurious);
        int n;
        for (n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            if (!a_busy) break;
            if (rnd_ready) a_vec_ready = ($urandom_range(0, 3) != 0);
            if (spurious)  a_start = ($urandom_range(0, 7) == 0);
        end
        a_start = 1'b0;
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL run_end_wait: busy=%b after 500 cycles, required 0", a_busy);
        end
    endtask

    task automatic b_respond(input logic [31:0] val);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_vec_valid && b_vec_ready) break;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL b_handshake_wait: vec_valid=%b, required 1 within 20 cycles", b_vec_valid);
        end
        @(posedge clk); #1;
        b_resp_valid = 1'b1;
        b_resp_data  = val;
        @(posedge clk); #1;
        b_resp_valid = 1'b0;
    endtask

    initial begin : main
        logic [31:0] bsig;
        int n;
        rst = 1'b1;
        a_start = 1'b0; a_vec_ready = 1'b0;
        b_start = 1'b0; b_vec_ready = 1'b0; b_resp_valid = 1'b0; b_resp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr0", 32'(a_mem_addr), 0);
        chk("rst_valid0", 32'(a_vec_valid), 0);
        chk("rst_data0", a_vec_data, 0);
        chk("rst_busy0", 32'(a_busy), 0);
        chk("rst_done0", 32'(a_done), 0);
        chk("rst_terr0", 32'(a_terr), 0);
        chk("rst_sig0", a_signature, 0);
        chk("rst_cnt0", 32'(a_vec_count), 0);
        chk("rst_b_busy0", 32'(b_busy), 0);
        rst = 1'b0;

        // Loopback: echoed responses, ready always high.
        a_vec_ready = 1'b1;
        start_a();
        run_a(1'b0, 1'b0);

        // Backpressure on the first vector.
        a_vec_ready = 1'b0;
        start_a();
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(a_vec_valid), 1);
            chk("bp_data", a_vec_data, 32'hff00f00f);
            chk("bp_addr", 32'(a_mem_addr), 0);
            chk("bp_cnt", 32'(a_vec_count), 0);
        end
        @(posedge clk); #1;
        a_vec_ready = 1'b1;
        run_a(1'b0, 1'b0);

        // Timeout on the third vector; flag stays up after the run.
        a_timeout_at = 2;
        start_a();
        run_a(1'b0, 1'b0);
        a_timeout_at = -1;
        repeat (3) begin
            @(negedge clk);
            chk("terr_sticky", 32'(a_terr), 1);
            chk("terr_idle_busy", 32'(a_busy), 0);
            chk("terr_no_done", 32'(a_done), 0);
        end

        // Response lands in the expiry cycle of vector 3.
        a_tie_at = 3;
        start_a();
        run_a(1'b0, 1'b0);
        a_tie_at = -1;

        // Reset while the first vector waits in SEND.
        a_vec_ready = 1'b0;
        start_a();
        repeat (2) @(negedge clk);
        exp_vec.delete();
        push_end(2, 32'h0, 0, -1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(a_vec_valid), 0);
        chk("rst_async_busy", 32'(a_busy), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        a_vec_ready = 1'b1;
        start_a();
        run_a(1'b0, 1'b0);

        // Randomised runs: random data, ready, ignored response noise and starts, occasional timeout.
        a_echo  = 1'b0;
        a_noise = 1'b1;
        for (int r = 0; r < 8; r++) begin
            a_timeout_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            start_a();
            run_a(1'b1, 1'b1);
        end
        a_timeout_at = -1;
        a_noise = 1'b0;
        a_vec_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Two-vector signature run on the second instance.
        bsig = rotx(rotx(32'h0, 32'h1), 32'h2);
        b_vec_ready = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_respond(32'h00000001);
        b_respond(32'h00000002);
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (b_done) break;
        end
        chk("b_done_seen", 32'(b_done), 1);
        chk("b_sig_model", b_signature, bsig);
        chk("b_sig_zero", b_signature, 32'h0);
        chk("b_cnt", 32'(b_vec_count), 2);
        repeat (5) @(negedge clk);
        chk("b_done_once", b_done_n, 1);
        chk("b_sig_held", b_signature, 32'h0);
        chk("b_busy_low", 32'(b_busy), 0);

        chk("queues_drained", exp_vec.size() + exp_end.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
